// File: rtl/arinc429_pkg.sv
// ARINC429 shared definitions: speed codes, line codes,
// receiver states and bit-time helpers.
package arinc429_pkg;

  localparam int CNT_W = 16;

  localparam logic [1:0] SPD_OFF  = 2'b00;
  localparam logic [1:0] SPD_12K5 = 2'b01;
  localparam logic [1:0] SPD_50K  = 2'b10;
  localparam logic [1:0] SPD_100K = 2'b11;

  // Encoding is {A,B} so the synchronized pair maps directly
  typedef enum logic [1:0] {
    LC_NULL = 2'b00,
    LC_LO   = 2'b01,
    LC_HI   = 2'b10,
    LC_ERR  = 2'b11
  } line_code_t;

  typedef enum logic [1:0] {
    S_SYNC,
    S_IDLE,
    S_BIT,
    S_NULL
  } rx_state_t;

  function automatic logic [CNT_W-1:0] tbit(
    input int unsigned clk_hz,
    input logic [1:0]  speed
  );
    int unsigned t;
    t = 0;
    case (speed)
      SPD_12K5: t = clk_hz / 32'd12500;
      SPD_50K:  t = clk_hz / 32'd50000;
      SPD_100K: t = clk_hz / 32'd100000;
      default:  t = 0;
    endcase
    return t[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] filt(
    input logic [CNT_W-1:0] t
  );
    return t >> 3;
  endfunction

endpackage

// File: rtl/arinc429_rx_line.sv
// ARINC429 line front end: synchronizers, code decode and
// glitch filter producing a qualified code plus change strobe.
module arinc429_rx_line
  import arinc429_pkg::*;
(
  input  logic             i_avs_clk,
  input  logic             i_avs_rst_n,
  input  logic [CNT_W-1:0] filt_i,
  input  logic             a_i,
  input  logic             b_i,
  output logic [1:0]       code_o,
  output logic             stb_o
);

  logic             a_meta_q, a_sync_q;
  logic             b_meta_q, b_sync_q;
  logic [1:0]       raw;
  logic [1:0]       cand_q, cand_d;
  logic [1:0]       qual_q, qual_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stb_q, stb_d;

  assign raw    = {a_sync_q, b_sync_q};
  assign code_o = qual_q;
  assign stb_o  = stb_q;

  // Synchronizers and filter state
  always_ff @(posedge i_avs_clk or negedge i_avs_rst_n) begin
    if (!i_avs_rst_n) begin
      a_meta_q <= 1'b0;
      a_sync_q <= 1'b0;
      b_meta_q <= 1'b0;
      b_sync_q <= 1'b0;
      cand_q   <= LC_NULL;
      qual_q   <= LC_NULL;
      cnt_q    <= '0;
      stb_q    <= 1'b0;
    end else begin
      a_meta_q <= a_i;
      a_sync_q <= a_meta_q;
      b_meta_q <= b_i;
      b_sync_q <= b_meta_q;
      cand_q   <= cand_d;
      qual_q   <= qual_d;
      cnt_q    <= cnt_d;
      stb_q    <= stb_d;
    end
  end

  // A candidate becomes qualified once held for filt_i cycles
  always_comb begin
    cand_d = cand_q;
    qual_d = qual_q;
    cnt_d  = cnt_q;
    stb_d  = 1'b0;
    if (raw != cand_q) begin
      cand_d = raw;
      cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      if (cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
      if (filt_i != '0 &&
          cnt_q >= filt_i - 1'b1 &&
          cand_q != qual_q) begin
        qual_d = cand_q;
        stb_d  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arinc429_rx.sv
// ARINC429 receiver: word recovery FSM, parity check and
// single-entry Avalon-ST output register.
module arinc429_rx
  import arinc429_pkg::*;
#(
  parameter int unsigned IN_AVS_CLK = 32'd50000000
) (
  input  logic        i_avs_clk,
  input  logic        i_avs_rst_n,
  input  logic [1:0]  i_arinc429_speed,
  input  logic        i_arinc429_rx_A,
  input  logic        i_arinc429_rx_B,
  output logic        o_src_valid,
  output logic [31:0] o_src_data,
  output logic        o_src_error,
  input  logic        i_src_ready,
  output logic        o_frame_err,
  output logic        o_overrun
);

  localparam logic [CNT_W-1:0] TB_12K5 =
    tbit(IN_AVS_CLK, SPD_12K5);
  localparam logic [CNT_W-1:0] TB_50K =
    tbit(IN_AVS_CLK, SPD_50K);
  localparam logic [CNT_W-1:0] TB_100K =
    tbit(IN_AVS_CLK, SPD_100K);

  rx_state_t        state_q, state_d;
  logic [1:0]       speed_q;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [31:0]      sr_q, sr_d;
  logic             valid_q, valid_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic             fe_q, fe_d;
  logic             ov_q, ov_d;
  logic [CNT_W-1:0] tbit_w;
  logic [1:0]       code;
  logic             stb, abort, emit, is_lvl, lvl_bit;

  assign o_src_valid = valid_q;
  assign o_src_data  = data_q;
  assign o_src_error = err_q;
  assign o_frame_err = fe_q;
  assign o_overrun   = ov_q;

  // Bit time for the selected speed
  always_comb begin
    tbit_w = '0;
    case (i_arinc429_speed)
      SPD_12K5: tbit_w = TB_12K5;
      SPD_50K:  tbit_w = TB_50K;
      SPD_100K: tbit_w = TB_100K;
      default:  tbit_w = '0;
    endcase
  end

  arinc429_rx_line u_line (
    .i_avs_clk   (i_avs_clk),
    .i_avs_rst_n (i_avs_rst_n),
    .filt_i      (filt(tbit_w)),
    .a_i         (i_arinc429_rx_A),
    .b_i         (i_arinc429_rx_B),
    .code_o      (code),
    .stb_o       (stb)
  );

  assign abort   = (i_arinc429_speed == SPD_OFF) ||
                   (i_arinc429_speed != speed_q);
  assign is_lvl  = stb && (code == LC_HI || code == LC_LO);
  assign lvl_bit = (code == LC_HI);

  // State, counters and output registers
  always_ff @(posedge i_avs_clk or negedge i_avs_rst_n) begin
    if (!i_avs_rst_n) begin
      state_q   <= S_SYNC;
      speed_q   <= SPD_OFF;
      bit_cnt_q <= '0;
      tmr_q     <= '0;
      sr_q      <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      speed_q   <= i_arinc429_speed;
      bit_cnt_q <= bit_cnt_d;
      tmr_q     <= tmr_d;
      sr_q      <= sr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      err_q     <= err_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  // Word framing FSM; timer restarts on every code or state change
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    emit      = 1'b0;
    fe_d      = 1'b0;
    unique case (state_q)
      S_SYNC: begin
        bit_cnt_d = '0;
        if (code == LC_NULL && tmr_q >= tbit_w - 1'b1)
          state_d = S_IDLE;
      end
      S_IDLE: begin
        bit_cnt_d = '0;
        if (is_lvl) begin
          sr_d[0]   = lvl_bit;
          bit_cnt_d = 6'd1;
          state_d   = S_BIT;
        end
      end
      S_BIT: begin
        if (stb && code == LC_NULL) begin
          state_d = S_NULL;
        end else if (stb || tmr_q >= tbit_w) begin
          fe_d    = 1'b1;
          state_d = S_SYNC;
        end
      end
      S_NULL: begin
        if (bit_cnt_q == 6'd32) begin
          emit    = 1'b1;
          state_d = S_SYNC;
        end else if (is_lvl) begin
          sr_d[bit_cnt_q[4:0]] = lvl_bit;
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = S_BIT;
        end else if (stb && code == LC_ERR) begin
          fe_d    = 1'b1;
          state_d = S_SYNC;
        end else if (tmr_q >= tbit_w - 1'b1) begin
          fe_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_SYNC;
    endcase
    if (abort) begin
      state_d   = S_SYNC;
      bit_cnt_d = '0;
      emit      = 1'b0;
      fe_d      = 1'b0;
    end
    if (stb || abort || state_d != state_q)
      tmr_d = '0;
    else if (tmr_q != '1)
      tmr_d = tmr_q + 1'b1;
    else
      tmr_d = tmr_q;
  end

  // Holding register with overrun detection
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    ov_d    = 1'b0;
    if (valid_q && i_src_ready)
      valid_d = 1'b0;
    if (emit) begin
      if (!valid_q || i_src_ready) begin
        valid_d = 1'b1;
        data_d  = sr_q;
        err_d   = ~^sr_q;
      end else begin
        ov_d = 1'b1;
      end
    end
    if (i_arinc429_speed == SPD_OFF)
      valid_d = 1'b0;
  end

endmodule

// File: tb/tb_arinc429_rx.sv
// Self-checking bench for arinc429_rx with a word-level
// line driver and reference expectations.
module tb_arinc429_rx;

  localparam int unsigned CLK_HZ = 10_000_000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  speed = 2'b11;
  logic        rx_A = 1'b0;
  logic        rx_B = 1'b0;
  logic        ready = 1'b1;
  logic        valid;
  logic [31:0] data;
  logic        err;
  logic        fe;
  logic        ov;

  int          n_checks = 0;
  int          n_pass = 0;
  int          fe_cnt = 0;
  int          ov_cnt = 0;
  logic [31:0] rx_q[$];
  logic        rx_e_q[$];

  always #5 clk = ~clk;

  arinc429_rx #(.IN_AVS_CLK(CLK_HZ)) dut (
    .i_avs_clk        (clk),
    .i_avs_rst_n      (rst_n),
    .i_arinc429_speed (speed),
    .i_arinc429_rx_A  (rx_A),
    .i_arinc429_rx_B  (rx_B),
    .o_src_valid      (valid),
    .o_src_data       (data),
    .o_src_error      (err),
    .i_src_ready      (ready),
    .o_frame_err      (fe),
    .o_overrun        (ov)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) begin
        rx_q.push_back(data);
        rx_e_q.push_back(err);
      end
      if (fe) fe_cnt++;
      if (ov) ov_cnt++;
    end
  end

  function automatic int bit_cycles(input logic [1:0] s);
    case (s)
      2'b01:   return CLK_HZ / 12500;
      2'b10:   return CLK_HZ / 50000;
      2'b11:   return CLK_HZ / 100000;
      default: return 0;
    endcase
  endfunction

  function automatic logic exp_err(input logic [31:0] w);
    return ($countones(w) % 2) == 0;
  endfunction

  task automatic drive(input logic [1:0] ab, input int n);
    {rx_A, rx_B} = ab;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [31:0] w, input int nb);
    int tb;
    tb = bit_cycles(speed);
    for (int i = 0; i < nb; i++) begin
      drive(w[i] ? 2'b10 : 2'b01, tb / 2);
      drive(2'b00, tb - tb / 2);
    end
  endtask

  task automatic gap(input int nt);
    drive(2'b00, nt * bit_cycles(speed));
  endtask

  task automatic wait_rx(input int n);
    int b;
    b = 4 * bit_cycles(speed);
    while (rx_q.size() < n && b > 0) begin
      @(posedge clk);
      #1;
      b--;
    end
    if (rx_q.size() < n) begin
      n_checks++;
      $display("FAIL wait_rx: timeout, have %0d want %0d",
               rx_q.size(), n);
    end
  endtask

  task automatic test_word(input string nm, input logic [31:0] w);
    int base, fb, ob;
    logic [31:0] gd;
    logic ge;
    base = rx_q.size();
    fb = fe_cnt;
    ob = ov_cnt;
    send_bits(w, 32);
    gap(2);
    wait_rx(base + 1);
    gd = (rx_q.size() > base) ? rx_q[base] : 32'hx;
    ge = (rx_e_q.size() > base) ? rx_e_q[base] : 1'bx;
    n_checks++;
    if (rx_q.size() !== base + 1)
      $display("FAIL %s count: got %0d want 1", nm, rx_q.size() - base);
    else n_pass++;
    n_checks++;
    if (gd !== w)
      $display("FAIL %s data: got %h want %h", nm, gd, w);
    else n_pass++;
    n_checks++;
    if (ge !== exp_err(w))
      $display("FAIL %s error: got %b want %b", nm, ge, exp_err(w));
    else n_pass++;
    n_checks++;
    if (fe_cnt - fb + ov_cnt - ob !== 0)
      $display("FAIL %s pulses: got %0d want 0", nm,
               fe_cnt - fb + ov_cnt - ob);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(2'b00, 3);
    n_checks++;
    if ({valid, data, err, fe, ov} !== 36'h0)
      $display("FAIL reset: got %b_%h_%b%b%b want all zero",
               valid, data, err, fe, ov);
    else n_pass++;
    gap(2);
  endtask

  task automatic test_basic();
    speed = 2'b11;
    test_word("basic_100k", 32'h0000_0001);
    speed = 2'b10;
    gap(2);
    test_word("parity_50k", 32'h0000_0003);
    speed = 2'b11;
    gap(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 2; i++)
      test_word("random", $urandom);
  endtask

  task automatic test_short_word();
    int base, fb;
    base = rx_q.size();
    fb = fe_cnt;
    send_bits($urandom, 20);
    gap(2);
    n_checks++;
    if (fe_cnt - fb !== 1)
      $display("FAIL short frame_err: got %0d want 1", fe_cnt - fb);
    else n_pass++;
    n_checks++;
    if (rx_q.size() !== base)
      $display("FAIL short count: got %0d want 0", rx_q.size() - base);
    else n_pass++;
    test_word("after_short", 32'h5A5A_0F0F);
  endtask

  task automatic test_overrun();
    int base, ob;
    base = rx_q.size();
    ob = ov_cnt;
    ready = 1'b0;
    send_bits(32'h8000_0001, 32);
    gap(2);
    send_bits(32'h8000_0002, 32);
    gap(2);
    n_checks++;
    if (ov_cnt - ob !== 1)
      $display("FAIL overrun pulses: got %0d want 1", ov_cnt - ob);
    else n_pass++;
    n_checks++;
    if ({valid, data, err} !== {1'b1, 32'h8000_0001, exp_err(32'h8000_0001)})
      $display("FAIL overrun held: got %b %h %b want 1 80000001 %b",
               valid, data, err, exp_err(32'h8000_0001));
    else n_pass++;
    n_checks++;
    if (rx_q.size() !== base)
      $display("FAIL overrun early: got %0d want 0", rx_q.size() - base);
    else n_pass++;
    ready = 1'b1;
    drive(2'b00, 3);
    n_checks++;
    if (rx_q.size() !== base + 1 ||
        (rx_q.size() > base && rx_q[base] !== 32'h8000_0001))
      $display("FAIL overrun drain: got %0d words want 1 of 80000001",
               rx_q.size() - base);
    else n_pass++;
    n_checks++;
    if (valid !== 1'b0)
      $display("FAIL overrun valid: got %b want 0", valid);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int base, fb;
    fb = fe_cnt;
    drive(2'b10, 8);
    drive(2'b00, bit_cycles(speed));
    n_checks++;
    if (fe_cnt - fb !== 0)
      $display("FAIL glitch frame_err: got %0d want 0", fe_cnt - fb);
    else n_pass++;
    test_word("after_glitch", 32'h1234_5678);
    base = rx_q.size();
    fb = fe_cnt;
    send_bits($urandom, 10);
    drive(2'b11, 100);
    gap(2);
    n_checks++;
    if (fe_cnt - fb !== 1 || rx_q.size() !== base)
      $display("FAIL err_code: got fe %0d words %0d want 1 0",
               fe_cnt - fb, rx_q.size() - base);
    else n_pass++;
    test_word("after_err", $urandom);
  endtask

  task automatic test_speed_change();
    int base, fb, ob;
    logic [31:0] w1, w4;
    w1 = $urandom;
    w4 = $urandom | 32'h1;
    ready = 1'b0;
    base = rx_q.size();
    send_bits(w1, 32);
    gap(2);
    fb = fe_cnt;
    ob = ov_cnt;
    send_bits($urandom, 10);
    drive(2'b10, 20);
    speed = 2'b10;
    gap(2);
    n_checks++;
    if ({valid, data} !== {1'b1, w1} || fe_cnt != fb || ov_cnt != ob)
      $display("FAIL spdchg held: got %b %h fe %0d ov %0d want 1 %h 0 0",
               valid, data, fe_cnt - fb, ov_cnt - ob, w1);
    else n_pass++;
    ready = 1'b1;
    drive(2'b00, 3);
    n_checks++;
    if (rx_q.size() !== base + 1 ||
        (rx_q.size() > base && rx_q[base] !== w1))
      $display("FAIL spdchg drain: got %0d words want 1", rx_q.size() - base);
    else n_pass++;
    test_word("new_speed", $urandom);
    ready = 1'b0;
    send_bits(w4, 32);
    gap(2);
    speed = 2'b00;
    drive(2'b00, 3);
    n_checks++;
    if ({valid, data} !== {1'b0, w4})
      $display("FAIL speed_off: got %b %h want 0 %h", valid, data, w4);
    else n_pass++;
    ready = 1'b1;
    speed = 2'b11;
    gap(2);
  endtask

  task automatic test_reset_mid();
    int base, fb, ob;
    base = rx_q.size();
    send_bits(32'hFFFF_FFFF, 12);
    drive(2'b10, 20);
    fb = fe_cnt;
    ob = ov_cnt;
    rst_n = 1'b0;
    drive(2'b10, 4);
    n_checks++;
    if ({valid, data, err, fe, ov} !== 36'h0)
      $display("FAIL reset_mid: got %b_%h_%b%b%b want all zero",
               valid, data, err, fe, ov);
    else n_pass++;
    rst_n = 1'b1;
    gap(2);
    n_checks++;
    if (rx_q.size() !== base || fe_cnt != fb || ov_cnt != ob)
      $display("FAIL reset_mid output: got words %0d fe %0d ov %0d want 0",
               rx_q.size() - base, fe_cnt - fb, ov_cnt - ob);
    else n_pass++;
    test_word("after_reset", $urandom);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_short_word();
    test_overrun();
    test_glitch();
    test_speed_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
